instr_decode_queue: RTL and testbench

Parametrised, buffered successor to the combinational instruction field interpreter. It accepts 32-bit instruction words over a valid/ready handshake into a DEPTH-entry FIFO and decodes the head entry. Decoded fields are held in a registered output stage with its own valid/ready handshake. It sits between instruction fetch and register-file read / hazard logic, and supports a flush for control-flow redirects.

---
 rtl/instr_decode_queue.sv | 174 +++++++++++++++++
 tb/tb_instr_decode_queue.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_decode_queue.sv
// Buffered instruction decoder: a DEPTH-entry FIFO feeding a registered decode stage.
// Build option: define IMM_SIGN_EXT_EN to sign-extend the 16-bit immediate (default zero-extend).
module instr_decode_queue #(
    parameter int DEPTH     = 4,
    parameter int IMM_OUT_W = 32,
    parameter int R_LO      = 1,
    parameter int R_HI      = 15,
    parameter int I_LO      = 16,
    parameter int I_HI      = 23,
    parameter int M_LO      = 24,
    parameter int M_HI      = 27
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [31:0]                in_instr,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [5:0]                 out_opcode,
    output logic [1:0]                 out_class,
    output logic [4:0]                 out_rd,
    output logic [4:0]                 out_rs,
    output logic [4:0]                 out_rt,
    output logic [4:0]                 out_shamt,
    output logic [IMM_OUT_W-1:0]       out_imm,
    output logic                       out_we,
    output logic                       out_use_rs,
    output logic                       out_use_rt,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [5:0]           opcode;
        logic [1:0]           cls;
        logic [4:0]           rd;
        logic [4:0]           rs;
        logic [4:0]           rt;
        logic [4:0]           shamt;
        logic [IMM_OUT_W-1:0] imm;
        logic                 we;
        logic                 use_rs;
        logic                 use_rt;
    } dec_t;

    logic [31:0]   r_mem [DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_vld_p1;
    dec_t          r_dec_p1;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_load;
    dec_t          w_dec_p0;

    function automatic logic in_range(input logic [5:0] op, input int lo, input int hi);
        int v;
        v = {26'd0, op};
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic [IMM_OUT_W-1:0] ext_imm(input logic [15:0] v);
        logic [IMM_OUT_W-1:0] r;
`ifdef IMM_SIGN_EXT_EN
        r = {IMM_OUT_W{v[15]}};
`else
        r = '0;
`endif
        r[15:0] = v;
        return r;
    endfunction

    function automatic dec_t decode(input logic [31:0] w);
        dec_t d;
        d        = '0;
        d.opcode = w[31:26];
        d.use_rs = 1'b1;
        d.use_rt = 1'b1;
        if (in_range(w[31:26], R_LO, R_HI)) begin
            d.cls   = 2'd0;
            d.rd    = w[25:21];
            d.rs    = w[20:16];
            d.rt    = w[15:11];
            d.shamt = w[10:6];
        end else if (in_range(w[31:26], I_LO, I_HI)) begin
            d.cls    = 2'd1;
            d.rd     = w[25:21];
            d.rs     = w[20:16];
            d.imm    = ext_imm(w[15:0]);
            d.use_rt = 1'b0;
        end else if (in_range(w[31:26], M_LO, M_HI)) begin
            d.cls = 2'd2;
            d.rd  = w[25:21];
            d.rs  = w[25:21];
            d.rt  = w[20:16];
            d.imm = ext_imm(w[15:0]);
        end else begin
            d.cls = 2'd3;
            d.rs  = w[25:21];
            d.rt  = w[20:16];
            d.imm = ext_imm(w[15:0]);
        end
        // Register 0 is hard-wired; writes to it are suppressed.
        d.we = (d.cls != 2'd3) && (d.rd != 5'd0);
        return d;
    endfunction

    assign w_full   = (r_count == CW'(DEPTH));
    assign w_empty  = (r_count == '0);
    assign in_ready = !w_full && !flush;
    assign w_push   = in_valid && in_ready;
    assign w_load   = (!r_vld_p1 || out_ready) && !w_empty && !flush;

    // ---- p0: FIFO storage and head decode
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_instr;
        end
    end

    assign w_dec_p0 = decode(r_mem[r_rd_ptr]);

    // ---- p1: registered output stage
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld_p1 <= 1'b0;
            r_dec_p1 <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_vld_p1 <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_load) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
                r_dec_p1 <= w_dec_p0;
                r_vld_p1 <= 1'b1;
            end else if (out_ready) begin
                r_vld_p1 <= 1'b0;
            end
            case ({w_push, w_load})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign out_valid  = r_vld_p1;
    assign out_opcode = r_dec_p1.opcode;
    assign out_class  = r_dec_p1.cls;
    assign out_rd     = r_dec_p1.rd;
    assign out_rs     = r_dec_p1.rs;
    assign out_rt     = r_dec_p1.rt;
    assign out_shamt  = r_dec_p1.shamt;
    assign out_imm    = r_dec_p1.imm;
    assign out_we     = r_dec_p1.we;
    assign out_use_rs = r_dec_p1.use_rs;
    assign out_use_rt = r_dec_p1.use_rt;
    assign count      = r_count;

endmodule

// File: tb/tb_instr_decode_queue.sv
// Bench for instr_decode_queue: decode vector table, handshake corner sequences, and
// randomized traffic checked against a queue-based reference model.
module tb_instr_decode_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [5:0]  opcode;
        logic [1:0]  cls;
        logic [4:0]  rd;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  shamt;
        logic [31:0] imm;
        logic        we;
        logic        use_rs;
        logic        use_rt;
    } fields_t;

    typedef struct {
        string       name;
        logic [31:0] instr;
        fields_t     exp;
    } vec_t;

`ifdef IMM_SIGN_EXT_EN
    localparam logic [31:0] IMM_FFFE = 32'hFFFF_FFFE;
    localparam logic [31:0] IMM_8001 = 32'hFFFF_8001;
    localparam logic [31:0] IMM_8000 = 32'hFFFF_8000;
`else
    localparam logic [31:0] IMM_FFFE = 32'h0000_FFFE;
    localparam logic [31:0] IMM_8001 = 32'h0000_8001;
    localparam logic [31:0] IMM_8000 = 32'h0000_8000;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_instr = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [5:0]  out_opcode;
    logic [1:0]  out_class;
    logic [4:0]  out_rd, out_rs, out_rt, out_shamt;
    logic [31:0] out_imm;
    logic        out_we, out_use_rs, out_use_rt;
    logic [2:0]  count;

    instr_decode_queue #(.DEPTH(DEPTH), .IMM_OUT_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_class(out_class),
        .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt), .out_shamt(out_shamt),
        .out_imm(out_imm), .out_we(out_we),
        .out_use_rs(out_use_rs), .out_use_rt(out_use_rt),
        .count(count)
    );

    always #5 clk = ~clk;

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] mq[$];
    bit          mv = 1'b0;
    fields_t     mf = '0;
    bit          mf_known = 1'b0;
    bit          pk;
    vec_t        tbl[10];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_ext(input logic [15:0] v);
`ifdef IMM_SIGN_EXT_EN
        return (v >= 16'h8000) ? {16'hFFFF, v} : {16'h0000, v};
`else
        return {16'h0000, v};
`endif
    endfunction

    // Spec-level decode: classify by integer opcode range, then pick fields for that class.
    function automatic fields_t ref_dec(input logic [31:0] w);
        fields_t f;
        int      op;
        op       = int'(w[31:26]);
        f        = '0;
        f.opcode = w[31:26];
        f.use_rs = 1'b1;
        f.use_rt = 1'b1;
        if (op >= 1 && op <= 15) begin
            f.cls = 2'd0; f.rd = w[25:21]; f.rs = w[20:16]; f.rt = w[15:11]; f.shamt = w[10:6];
        end else if (op >= 16 && op <= 23) begin
            f.cls = 2'd1; f.rd = w[25:21]; f.rs = w[20:16]; f.imm = ref_ext(w[15:0]); f.use_rt = 1'b0;
        end else if (op >= 24 && op <= 27) begin
            f.cls = 2'd2; f.rd = w[25:21]; f.rs = w[25:21]; f.rt = w[20:16]; f.imm = ref_ext(w[15:0]);
        end else begin
            f.cls = 2'd3; f.rs = w[25:21]; f.rt = w[20:16]; f.imm = ref_ext(w[15:0]);
        end
        f.we = (f.cls != 2'd3) && (f.rd != 5'd0);
        return f;
    endfunction

    function automatic fields_t act_fields();
        return '{out_opcode, out_class, out_rd, out_rs, out_rt, out_shamt,
                 out_imm, out_we, out_use_rs, out_use_rt};
    endfunction

    function automatic vec_t mk(input string nm, input logic [31:0] w, input int op, input int cls,
                                input int rd, input int rs, input int rt, input int sh,
                                input logic [31:0] imm, input bit we, input bit urs, input bit urt);
        vec_t v;
        v.name  = nm;
        v.instr = w;
        v.exp   = '{6'(op), 2'(cls), 5'(rd), 5'(rs), 5'(rt), 5'(sh), imm, we, urs, urt};
        return v;
    endfunction

    function automatic logic [31:0] rdw(input int k);
        return {6'd1, 5'(k), 21'd0};
    endfunction

    // One clock: drive inputs, check in_ready, advance the model, then check registered outputs.
    task automatic cycle(input bit r, input bit v, input logic [31:0] w, input bit ordy,
                         input bit fl, output bit pushed);
        bit exp_rdy;
        bit ld;
        rst = r; in_valid = v; in_instr = w; out_ready = ordy; flush = fl;
        #1;
        exp_rdy = (mq.size() != DEPTH) && !fl;
        if (!r) chk("in_ready", in_ready, exp_rdy);
        pushed = 1'b0;
        if (r) begin
            mq.delete(); mv = 1'b0; mf = '0; mf_known = 1'b1;
        end else if (fl) begin
            mq.delete(); mv = 1'b0; mf_known = 1'b0;
        end else begin
            ld     = (!mv || ordy) && (mq.size() != 0);
            pushed = v && exp_rdy;
            if (ld) begin
                mf = ref_dec(mq.pop_front()); mv = 1'b1; mf_known = 1'b1;
            end else if (ordy) begin
                mv = 1'b0;
            end
            if (pushed) mq.push_back(w);
        end
        @(posedge clk);
        #1;
        chk("count", count, mq.size());
        chk("out_valid", out_valid, mv);
        if (mf_known) chk("fields", act_fields(), mf);
    endtask

    initial begin
        tbl[0] = mk("R",      32'h0464_2880,  1, 0, 3, 4, 5, 2, 32'd0,    1, 1, 1);
        tbl[1] = mk("I_ext",  32'h4041_FFFE, 16, 1, 2, 1, 0, 0, IMM_FFFE, 1, 1, 0);
        tbl[2] = mk("M",      32'h60E8_0010, 24, 2, 7, 7, 8, 0, 32'h10,   1, 1, 1);
        tbl[3] = mk("other",  32'h70E8_0010, 28, 3, 0, 7, 8, 0, 32'h10,   0, 1, 1);
        tbl[4] = mk("R_rd0",  32'h0404_2880,  1, 0, 0, 4, 5, 2, 32'd0,    0, 1, 1);
        tbl[5] = mk("op0",    32'h0000_0000,  0, 3, 0, 0, 0, 0, 32'd0,    0, 1, 1);
        tbl[6] = mk("op63",   32'hFFFF_8001, 63, 3, 0, 31, 31, 0, IMM_8001, 0, 1, 1);
        tbl[7] = mk("R_hi",   32'h3C22_1234, 15, 0, 1, 2, 2, 8, 32'd0,    1, 1, 1);
        tbl[8] = mk("I_hi",   32'h5C20_8000, 23, 1, 1, 0, 0, 0, IMM_8000, 1, 1, 0);
        tbl[9] = mk("M_hi",   32'h6C00_0005, 27, 2, 0, 0, 0, 0, 32'h5,    0, 1, 1);

        // Reset held two cycles with in_valid high: nothing may be accepted.
        cycle(1, 1, 32'h0464_2880, 0, 0, pk);
        cycle(1, 1, 32'h4041_FFFE, 1, 1, pk);
        chk("rst_count", count, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_fields", act_fields(), '0);

        for (int i = 0; i < 10; i++) begin
            cycle(0, 1, tbl[i].instr, 1, 0, pk);
            chk({"nobypass_", tbl[i].name}, out_valid, 0);
            cycle(0, 0, 32'd0, 1, 0, pk);
            chk({"tbl_valid_", tbl[i].name}, out_valid, 1);
            chk({"tbl_", tbl[i].name}, act_fields(), tbl[i].exp);
        end
        cycle(0, 0, 32'd0, 1, 0, pk);

        // Backpressure: first word parks in the output stage, four fill the FIFO, sixth waits.
        for (int k = 1; k <= 6; k++) cycle(0, 1, rdw(k), 0, 0, pk);
        chk("bp_count_full", count, 4);
        chk("bp_in_ready", in_ready, 0);
        chk("bp_head_rd", out_rd, 1);
        begin
            bit taken;
            taken = 1'b0;
            for (int k = 2; k <= 6; k++) begin
                cycle(0, !taken, rdw(6), 1, 0, pk);
                if (pk) taken = 1'b1;
                chk("bp_order_valid", out_valid, 1);
                chk("bp_order_rd", out_rd, k);
            end
        end
        cycle(0, 0, 32'd0, 1, 0, pk);
        cycle(0, 0, 32'd0, 1, 0, pk);

        // Flush with count=3 and a held output, while a new word is offered.
        for (int k = 1; k <= 4; k++) cycle(0, 1, rdw(10 + k), 0, 0, pk);
        chk("fl_pre_count", count, 3);
        chk("fl_pre_valid", out_valid, 1);
        cycle(0, 1, rdw(20), 0, 1, pk);
        chk("fl_count", count, 0);
        chk("fl_valid", out_valid, 0);
        cycle(0, 1, rdw(21), 1, 0, pk);
        cycle(0, 0, 32'd0, 1, 0, pk);
        chk("fl_after_valid", out_valid, 1);
        chk("fl_after_rd", out_rd, 21);

        // Randomized traffic with alternating light/heavy consumer backpressure.
        for (int i = 0; i < 1200; i++) begin
            bit          r, v, o, f;
            logic [31:0] w;
            r = ($urandom % 200) == 0;
            f = ($urandom % 40) == 0;
            v = ($urandom % 4) != 0;
            o = ((i / 100) % 2 == 0) ? (($urandom % 5) != 0) : (($urandom % 4) == 0);
            w = $urandom;
            cycle(r, v, w, o, f, pk);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
